// File: rtl/dip_led_ctrl.sv
// -----------------------------------------------------------------------------
// dip_led_ctrl
//
// Front-panel switch-to-LED controller. Raw DIP switches are synchronised and
// debounced per bit. The debounced bank then drives an equal-width LED bank in
// one of four run-time selectable modes:
//   00 PASS    : led follows the debounced switches
//   01 BLINK   : debounced pattern gated on/off every BLINK_TICKS prescaler ticks
//   10 MARQUEE : snapshot of the pattern rotated left once per tick
//   11 DIM     : debounced pattern gated by a free-running PWM counter vs duty
//
// Ports
//   clk    in  1         single clock, all state on rising edge
//   rst_n  in  1         asynchronous active-low reset, release synchronous
//   dip    in  WIDTH     raw switch inputs (asynchronous)
//   mode   in  2         mode select (asynchronous, synchronised here)
//   duty   in  PWM_BITS  DIM on-time in PWM counts (synchronous to clk)
//   led    out WIDTH     registered LED drive, active-high
//   tick   out 1         one-cycle prescaler pulse
// -----------------------------------------------------------------------------
module dip_led_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DEB_CYCLES  = 16,
  parameter int TICK_DIV    = 50000,
  parameter int BLINK_TICKS = 8,
  parameter int PWM_BITS    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    dip,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] duty,
  output logic [WIDTH-1:0]    led,
  output logic                tick
);

  // Counter widths sized to hold 0..N-1 (at least one bit each).
  localparam int DW = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
  localparam int PW = (TICK_DIV    > 1) ? $clog2(TICK_DIV)    : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PCNT_LAST  = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    MODE_PASS    = 2'b00,
    MODE_BLINK   = 2'b01,
    MODE_MARQUEE = 2'b10,
    MODE_DIM     = 2'b11
  } mode_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers for the switch bank and the mode select.
  // mode_q is a delayed copy of mode_s used only to detect mode entry.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] dip_meta;
  logic [WIDTH-1:0] dip_s;
  logic [1:0]       mode_meta;
  logic [1:0]       mode_s;
  logic [1:0]       mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dip_meta  <= '0;
      dip_s     <= '0;
      mode_meta <= '0;
      mode_s    <= '0;
      mode_q    <= '0;
    end else begin
      dip_meta  <= dip;
      dip_s     <= dip_meta;
      mode_meta <= mode;
      mode_s    <= mode_meta;
      mode_q    <= mode_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bit debounce. A bit's counter runs only while the synchronised input
  // disagrees with the debounced value; any agreement restarts the count, so
  // only a disagreement lasting DEB_CYCLES consecutive cycles is accepted.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] deb;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_deb
      logic [DW-1:0] cnt;
      logic          deb_bit;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt     <= '0;
          deb_bit <= 1'b0;
        end else if (dip_s[gi] == deb_bit) begin
          cnt <= '0;
        end else if (cnt == DEB_LAST) begin
          deb_bit <= dip_s[gi];
          cnt     <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign deb[gi] = deb_bit;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Mode engine state
  // ---------------------------------------------------------------------------
  mode_t               mode_cur;
  logic                entry;
  logic [PW-1:0]       pcnt;
  logic [PW-1:0]       pcnt_next;
  logic [BW-1:0]       bcnt;
  logic [BW-1:0]       bcnt_next;
  logic                phase;
  logic                phase_next;
  logic [WIDTH-1:0]    mq;
  logic [WIDTH-1:0]    mq_next;
  logic [WIDTH-1:0]    mq_rot;
  logic [WIDTH-1:0]    mq_load;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] pwm_next;
  logic [WIDTH-1:0]    led_next;

  assign mode_cur = mode_t'(mode_s);
  assign entry    = (mode_s != mode_q);
  assign tick     = (pcnt == PCNT_LAST);

  // Marquee never starts dark: an all-zero pattern is replaced by a single lit LSB.
  assign mq_load = (deb == '0) ? WIDTH'(1) : deb;

  // Left rotate with MSB wrapping into bit 0; a one-LED bank is its own rotation.
  generate
    if (WIDTH == 1) begin : g_rot_one
      assign mq_rot = mq;
    end else begin : g_rot_many
      assign mq_rot = {mq[WIDTH-2:0], mq[WIDTH-1]};
    end
  endgenerate

  // Next-state and LED selection. The LED value is derived from the post-edge
  // view of phase/mq/pwm_cnt so the LED and the state it reflects update on
  // the same edge, and a new mode is visible one cycle after mode_s changes.
  always_comb begin
    pcnt_next  = pcnt;
    bcnt_next  = bcnt;
    phase_next = phase;
    mq_next    = mq;
    pwm_next   = pwm_cnt + 1'b1;
    led_next   = '0;

    if (entry) begin
      // Entry wins over a coincident tick: everything restarts from zero and
      // the tick is not applied to phase or the marquee.
      pcnt_next  = '0;
      bcnt_next  = '0;
      phase_next = 1'b1;
      pwm_next   = '0;
      mq_next    = mq_load;
    end else begin
      pcnt_next = tick ? '0 : pcnt + 1'b1;
      if (tick) begin
        case (mode_cur)
          MODE_BLINK: begin
            if (bcnt == BLINK_LAST) begin
              bcnt_next  = '0;
              phase_next = ~phase;
            end else begin
              bcnt_next = bcnt + 1'b1;
            end
          end
          MODE_MARQUEE: mq_next = mq_rot;
          default: ;
        endcase
      end
    end

    case (mode_cur)
      MODE_PASS:    led_next = deb;
      MODE_BLINK:   led_next = phase_next ? deb : '0;
      MODE_MARQUEE: led_next = mq_next;
      MODE_DIM:     led_next = (pwm_next < duty) ? deb : '0;
      default:      led_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt    <= '0;
      bcnt    <= '0;
      phase   <= 1'b1;
      mq      <= '0;
      pwm_cnt <= '0;
      led     <= '0;
    end else begin
      pcnt    <= pcnt_next;
      bcnt    <= bcnt_next;
      phase   <= phase_next;
      mq      <= mq_next;
      pwm_cnt <= pwm_next;
      led     <= led_next;
    end
  end

endmodule

// File: tb/tb_dip_led_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dip_led_ctrl
//
// Scoreboard bench. A reference model advanced on every rising edge pushes the
// expected {led, tick} into a queue; an independent monitor pops and compares
// one entry per cycle. The model works from elapsed time since the last mode
// entry and from a sliding window of synchronised samples rather than from the
// design's counters. Directed scenarios plus a randomized phase drive it.
// -----------------------------------------------------------------------------
module tb_dip_led_ctrl;

  localparam int W  = 8;
  localparam int DC = 4;
  localparam int TD = 4;
  localparam int BT = 2;
  localparam int PB = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  dip   = '0;
  logic [1:0]    mode  = 2'b00;
  logic [PB-1:0] duty  = '0;
  logic [W-1:0]  led;
  logic          tick;

  int checks   = 0;
  int failures = 0;

  dip_led_ctrl #(
    .WIDTH(W), .DEB_CYCLES(DC), .TICK_DIV(TD), .BLINK_TICKS(BT), .PWM_BITS(PB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dip(dip), .mode(mode), .duty(duty),
    .led(led), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0] led;
    logic         tick;
  } exp_t;

  exp_t sb[$];

  logic [W-1:0] m_s1, m_s, m_deb, m_reload;
  logic [1:0]   m_ms1, m_ms, m_mq;
  logic [W-1:0] m_hist [DC];
  int           m_since;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int n);
    logic [W-1:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[W-2:0], r[W-1]};
    return r;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s = '0; m_deb = '0; m_reload = '0;
    m_ms1 = '0; m_ms = '0; m_mq = '0;
    m_since = 0;
    for (int i = 0; i < DC; i++) m_hist[i] = '0;
  endtask

  task automatic model_step();
    logic   entry;
    exp_t   e;
    int     ticks;
    int     n_diff;
    entry = (m_ms != m_mq);
    // m_since: cycles elapsed since the last mode entry (or reset)
    if (entry) begin
      m_since  = 0;
      m_reload = (m_deb == '0) ? W'(1) : m_deb;
    end else begin
      m_since = m_since + 1;
    end
    ticks = m_since / TD;
    case (m_ms)
      2'b00:   e.led = m_deb;
      2'b01:   e.led = (((ticks / BT) % 2) == 0) ? m_deb : '0;
      2'b10:   e.led = rotl(m_reload, ticks % W);
      default: e.led = ((m_since % (1 << PB)) < int'(duty)) ? m_deb : '0;
    endcase
    e.tick = ((m_since % TD) == TD - 1);
    sb.push_back(e);
    // Debounce: a bit flips once the last DC synchronised samples all disagree.
    for (int i = DC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = m_s;
    for (int b = 0; b < W; b++) begin
      n_diff = 0;
      for (int j = 0; j < DC; j++) if (m_hist[j][b] != m_deb[b]) n_diff++;
      if (n_diff == DC) m_deb[b] = ~m_deb[b];
    end
    m_mq  = m_ms;
    m_ms  = m_ms1;
    m_ms1 = mode;
    m_s   = m_s1;
    m_s1  = dip;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        sb.delete();
      end else begin
        model_step();
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_led", 32'(led), 32'(e.led));
        check("sb_tick", 32'(tick), 32'(e.tick));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at a negedge where the next pre-edge prescaler count is
  // such that a mode written now becomes a mode entry on a tick cycle.
  task automatic align_to_tick();
    int found;
    found = 0;
    for (int i = 0; i < 4 * TD; i++) begin
      @(negedge clk);
      if (tick) begin
        found = 1;
        break;
      end
    end
    check("tick_seen", 32'(found), 32'd1);
    idle(2);
  endtask

  // Sample led at fixed offsets after a mode write (entry edge is the 3rd edge).
  task automatic check_marquee(input string name, input logic [W-1:0] e0,
                               input logic [W-1:0] e1, input logic [W-1:0] e2,
                               input logic [W-1:0] e3);
    logic [W-1:0] exp_seq [4];
    exp_seq[0] = e0; exp_seq[1] = e1; exp_seq[2] = e2; exp_seq[3] = e3;
    repeat (3) @(posedge clk);
    #1;
    check(name, 32'(led), 32'(exp_seq[0]));
    for (int s = 1; s < 4; s++) begin
      repeat (TD) @(posedge clk);
      #1;
      check(name, 32'(led), 32'(exp_seq[s]));
    end
  endtask

  task automatic count_on(input string name, input logic [W-1:0] pat, input int exp_n);
    int n;
    n = 0;
    for (int i = 0; i < (1 << PB); i++) begin
      @(posedge clk);
      #1;
      if (led == pat) n++;
    end
    check(name, 32'(n), 32'(exp_n));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    int k;

    // Reset state
    idle(3);
    check("reset_led", 32'(led), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    rst_n = 1'b1;

    // PASS latency for a held pattern
    idle(2);
    dip = 8'hA5;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (led == 8'hA5) begin
        lat = i;
        break;
      end
    end
    check("pass_latency", 32'(lat), 32'd7);
    idle(5);

    // Asynchronous reset mid-run
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_led", 32'(led), 32'd0);
    idle(2);
    rst_n = 1'b1;

    // Glitch rejection and acceptance on dip[0]
    dip = 8'h00;
    idle(12);
    dip[0] = 1'b1; idle(3); dip[0] = 1'b0;
    idle(12);
    check("short_pulse_led", 32'(led), 32'd0);
    dip[0] = 1'b1; idle(6); dip[0] = 1'b0;
    idle(14);

    // BLINK with deb=0F
    dip = 8'h0F;
    idle(10);
    mode = 2'b01;
    idle(40);

    // MARQUEE from deb=81, then from deb=00
    mode = 2'b00;
    dip  = 8'h81;
    idle(10);
    mode = 2'b10;
    check_marquee("marquee_81", 8'h81, 8'h03, 8'h06, 8'h0C);
    idle(4);
    mode = 2'b00;
    dip  = 8'h00;
    idle(10);
    mode = 2'b10;
    check_marquee("marquee_zero", 8'h01, 8'h02, 8'h04, 8'h08);
    idle(6);

    // Mode entries landing on tick cycles
    dip = 8'h81;
    idle(10);
    align_to_tick();
    mode = 2'b01;
    idle(7);
    align_to_tick();
    mode = 2'b10;
    check_marquee("marquee_on_tick", 8'h81, 8'h03, 8'h06, 8'h0C);
    idle(3);

    // DIM duty sweep
    mode = 2'b00;
    dip  = 8'hFF;
    idle(10);
    duty = 4'd4;
    mode = 2'b11;
    idle(4);
    count_on("dim_duty4", 8'hFF, 4);
    @(negedge clk);
    duty = 4'd0;
    idle(2);
    count_on("dim_duty0", 8'hFF, 0);
    @(negedge clk);
    duty = 4'd15;
    idle(2);
    count_on("dim_duty15", 8'hFF, 15);

    // Randomized mix of modes, patterns, glitches and duty changes
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) dip = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        k = $urandom_range(0, W - 1);
        dip[k] = ~dip[k];
      end
      if ($urandom_range(0, 15) == 0) duty = 4'($urandom);
    end

    idle(4);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dip_led_ctrl.md
# dip_led_ctrl

Parametrised switch-to-LED controller for the board front panel. It synchronises and debounces a bank of DIP switches, then drives an equal-width LED bank. Four modes are selectable at run time: direct pass-through, blink, rotating marquee, and PWM dimming. It replaces the combinational DIP-to-LED wire and sits between the board pins and the top level.

## Interface

Parameters:
- WIDTH, 8: number of DIP inputs and LED outputs (≥1).
- DEB_CYCLES, 16: consecutive cycles a synchronised input must differ from its debounced value before the debounced value changes (≥1).
- TICK_DIV, 50000: prescaler period in clk cycles. It sets the blink and marquee rate (≥2).
- BLINK_TICKS, 8: ticks per blink half-period (≥1).
- PWM_BITS, 4: width of the PWM counter and the duty input (≥1).

Ports:
- clk, in, 1: the single clock. Every register is on its rising edge.
- rst_n, in, 1: asynchronous, active-low reset. Assertion clears all state immediately. Release is synchronous to clk.
- dip, in, WIDTH: raw switch inputs, asynchronous to clk.
- mode, in, 2: 00 PASS, 01 BLINK, 10 MARQUEE, 11 DIM. It is asynchronous to clk and synchronised internally.
- duty, in, PWM_BITS: DIM on-time in PWM counts. It is sampled every cycle, so it must be driven synchronously to clk.
- led, out, WIDTH: registered LED drive, active-high.
- tick, out, 1: one-cycle prescaler pulse, exposed for verification.

## Operation

- **Synchronisers:** each dip bit and each mode bit passes through a 2-flop synchroniser. The results are dip_s and mode_s.
- **Debounce, per bit:**
  - When dip_s[i] equals deb[i], the bit's counter is cleared.
  - When they differ, the counter increments.
  - On the edge where the counter equals DEB_CYCLES-1 and the bit still differs, deb[i] takes dip_s[i] and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles never reaches deb.
- **Prescaler:**
  - pcnt counts 0 to TICK_DIV-1 and wraps.
  - tick is high for the cycle in which pcnt equals TICK_DIV-1.
- **Mode change:** when mode_s differs from its registered copy mode_q, that cycle is a mode-entry cycle. On a mode-entry cycle:
  - pcnt, the blink tick count, and pwm_cnt clear to 0;
  - phase is set to 1;
  - the marquee register is reloaded.
- **led next-value, by mode:**
  - PASS: led ← deb.
  - BLINK:
    - led ← deb when phase=1, else 0;
    - the blink counter counts ticks;
    - after BLINK_TICKS ticks, phase toggles and the counter clears.
  - MARQUEE:
    - On entry, mq ← deb, or mq ← 1 (LSB set) if deb is all zero.
    - On each later tick, mq rotates left by one: bit WIDTH-1 wraps to bit 0.
    - led ← mq.
    - Changes to deb during MARQUEE are ignored until the next entry.
  - DIM:
    - pwm_cnt is a free-running PWM_BITS-bit counter, incremented every cycle, wrapping at 2^PWM_BITS.
    - led ← deb when pwm_cnt < duty, else 0.
    - duty=0 gives always off.
    - duty = 2^PWM_BITS-1 gives off for exactly one cycle per period.
- **Reset values:**
  - All zero: led, tick, deb, synchronisers, all counters, mq, mode_q.
  - phase = 1.
  - The first cycle after reset release is treated as PASS with no entry event.
- **Mid-operation reset:** assertion forces led=0 within the same cycle, without waiting for a clock edge. No state survives.
- **Simultaneous events:** a mode-entry on a tick cycle takes priority. The counters clear and the tick is not applied to phase or mq.

## Timing

- dip change to deb change: 2 cycles (sync) + DEB_CYCLES cycles.
- deb to led in PASS: 1 cycle. Total dip-to-led latency is DEB_CYCLES+3 cycles when the input is stable.
- mode change to mode_s: 2 cycles. mode_s change to led in the new mode: 1 cycle.
- tick period: exactly TICK_DIV cycles. The first tick after a mode entry is TICK_DIV cycles later.
- Blink half-period: BLINK_TICKS×TICK_DIV cycles.
- Marquee step: TICK_DIV cycles.
- PWM period: 2^PWM_BITS cycles.

## Test plan

All scenarios use WIDTH=8, DEB_CYCLES=4, TICK_DIV=4, BLINK_TICKS=2, PWM_BITS=4.

1. Reset, then PASS with dip=8'hA5 held → led=8'h00 until DEB_CYCLES+3=7 cycles after the change, then 8'hA5. Asserting rst_n=0 mid-run drops led to 0 immediately.
2. PASS with steady dip=8'h00 and a 3-cycle pulse on dip[0] → led stays 8'h00. A 6-cycle pulse makes led[0]=1.
3. deb=8'h0F, switch to BLINK → led=8'h0F for 8 cycles, then 8'h00 for 8 cycles, repeating. tick pulses every 4 cycles.
4. deb=8'h81, enter MARQUEE → led=8'h81, then 8'h03, 8'h06, 8'h0C at 4-cycle steps. With deb=8'h00, entry gives 8'h01 first.
5. DIM with deb=8'hFF and duty=4 → led=8'hFF for 4 of every 16 cycles. duty=0 gives constant 8'h00. duty=15 gives 15 of 16 cycles on.
6. Mode change on a tick cycle in MARQUEE → no rotation on that cycle. mq reloads from deb and the next step comes 4 cycles later.
